// File: rtl/l2_word_responder.sv
// Responder end of the L1-to-L2 word interface: local word reads/writes plus
// remote write-through, each remote write followed by an L1 flush/busy-hold sequence.
module l2_word_responder #(
    parameter int unsigned n          = 32,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned FLUSH_HOLD = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] L2_word_address,
    input  logic              L2_read_request,
    input  logic              L2_write_request,
    input  logic [n-1:0]      L2_write_word,
    input  logic              L1_busy,
    input  logic              remote_wvalid,
    input  logic [ADDR_W-1:0] remote_waddr,
    input  logic [n-1:0]      remote_wdata,
    output logic              remote_wready,
    output logic [n-1:0]      L2_read_word,
    output logic              L2_busy,
    output logic              flush,
    output logic [CNT_W-1:0]  read_count,
    output logic [CNT_W-1:0]  write_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned HOLD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [n-1:0]        mem [DEPTH];
    logic                idle_c;
    logic                rd_en_c;
    logic                wr_en_c;

    assign idle_c  = (state_q == IDLE);
    assign rd_en_c = idle_c & L2_read_request & ~L2_write_request;
    assign wr_en_c = idle_c & L2_write_request;

    // Remote writes only slip in when the local L1 is quiet, so the flush never races an L1 access.
    assign remote_wready = idle_c & remote_wvalid & ~L1_busy & ~L2_read_request & ~L2_write_request;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Next-state logic for the flush/hold sequence
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (remote_wready) state_d = FLUSH;
            end
            FLUSH: begin
                hold_d  = HOLD_W'(FLUSH_HOLD - 1);
                state_d = HOLD;
            end
            HOLD: begin
                if (hold_q == '0) state_d = IDLE;
                else              hold_d  = hold_q - HOLD_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Busy/flush are registered copies of the next state, so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            L2_busy <= 1'b0;
            flush   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            L2_busy <= (state_d != IDLE);
            flush   <= (state_d == FLUSH);
        end
    end

    // Read data and saturating statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            L2_read_word <= '0;
            read_count   <= '0;
            write_count  <= '0;
            flush_count  <= '0;
        end else begin
            if (rd_en_c) begin
                L2_read_word <= mem[L2_word_address];
                read_count   <= sat_inc(read_count);
            end
            if (wr_en_c || remote_wready) write_count <= sat_inc(write_count);
            if (state_q == FLUSH)         flush_count <= sat_inc(flush_count);
        end
    end

    // Word memory; contents survive reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_en_c)            mem[L2_word_address] <= L2_write_word;
            else if (remote_wready) mem[remote_waddr]    <= remote_wdata;
        end
    end

endmodule

// File: tb/tb_l2_word_responder.sv
// Directed bench for l2_word_responder with a read-data scoreboard; a second
// instance with 4-bit counters covers saturation.
module tb_l2_word_responder;

    localparam int unsigned N  = 32;
    localparam int unsigned AW = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] addr;
    logic          rd_req, wr_req, l1_busy, rvalid;
    logic [N-1:0]  wword, rdata;
    logic [AW-1:0] raddr;

    logic          wready, busy, flush;
    logic [N-1:0]  rword;
    logic [15:0]   rcnt, wcnt, fcnt;

    logic          s_wready, s_busy, s_flush;
    logic [N-1:0]  s_rword;
    logic [3:0]    s_rcnt, s_wcnt, s_fcnt;

    int total = 0;
    int bad   = 0;
    int exp_rd = 0, exp_wr = 0, exp_fl = 0;
    int exp_rd4 = 0;
    logic [N-1:0] model [int];
    logic [N-1:0] sb_q [$];

    always #5 clk = ~clk;

    l2_word_responder #(.n(N), .ADDR_W(AW), .FLUSH_HOLD(2), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .L2_word_address(addr), .L2_read_request(rd_req),
        .L2_write_request(wr_req), .L2_write_word(wword), .L1_busy(l1_busy),
        .remote_wvalid(rvalid), .remote_waddr(raddr), .remote_wdata(rdata),
        .remote_wready(wready), .L2_read_word(rword), .L2_busy(busy), .flush(flush),
        .read_count(rcnt), .write_count(wcnt), .flush_count(fcnt)
    );

    l2_word_responder #(.n(N), .ADDR_W(AW), .FLUSH_HOLD(2), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .L2_word_address(addr), .L2_read_request(rd_req),
        .L2_write_request(wr_req), .L2_write_word(wword), .L1_busy(l1_busy),
        .remote_wvalid(rvalid), .remote_waddr(raddr), .remote_wdata(rdata),
        .remote_wready(s_wready), .L2_read_word(s_rword), .L2_busy(s_busy), .flush(s_flush),
        .read_count(s_rcnt), .write_count(s_wcnt), .flush_count(s_fcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_rcnt"}, 32'(rcnt), 32'(exp_rd));
        chk({tag, "_wcnt"}, 32'(wcnt), 32'(exp_wr));
        chk({tag, "_fcnt"}, 32'(fcnt), 32'(exp_fl));
        chk({tag, "_sat_rcnt"}, 32'(s_rcnt), 32'(exp_rd4));
    endtask

    task automatic wait_idle(input string tag);
        int n_cyc = 0;
        while (busy === 1'b1 && n_cyc < 20) begin
            tick();
            n_cyc++;
        end
        if (busy !== 1'b0) chk({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    // Issue one remote write, return once it is accepted (bounded).
    task automatic remote_write(input string tag, input logic [AW-1:0] a, input logic [N-1:0] d);
        int n_cyc = 0;
        rvalid = 1'b1; raddr = a; rdata = d;
        #1;
        while (wready !== 1'b1 && n_cyc < 20) begin
            tick();
            n_cyc++;
        end
        if (wready !== 1'b1) chk({tag, "_accept_timeout"}, 32'(wready), 32'd1);
        tick();
        rvalid = 1'b0;
        model[int'(a)] = d;
        exp_wr++;
        exp_fl++;
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a);
        rd_req = 1'b1; addr = a;
        sb_q.push_back(model.exists(int'(a)) ? model[int'(a)] : 32'h0);
        tick();
        exp_rd++;
        exp_rd4 = (exp_rd4 < 15) ? exp_rd4 + 1 : 15;
        chk(tag, rword, sb_q.pop_front());
        rd_req = 1'b0;
    endtask

    initial begin
        int busy_cyc, flush_cyc;
        logic [N-1:0] held;

        reset = 1'b1; addr = '0; rd_req = 1'b0; wr_req = 1'b0; wword = '0;
        l1_busy = 1'b0; rvalid = 1'b0; raddr = '0; rdata = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_rword", rword, 32'd0);
        chk_counts("rst");

        // Preload via remote writes, then a 16-address refill burst
        for (int i = 0; i < 16; i++) begin
            remote_write("preload", AW'(16'h4A0 + i), 32'h1000 + 32'(i));
            wait_idle("preload");
        end
        for (int i = 0; i < 16; i++) begin
            rd_req = 1'b1; addr = AW'(16'h4A0 + i);
            sb_q.push_back(32'h1000 + 32'(i));
            tick();
            exp_rd++;
            exp_rd4 = (exp_rd4 < 15) ? exp_rd4 + 1 : 15;
            chk("refill_data", rword, sb_q.pop_front());
        end
        rd_req = 1'b0;
        chk_counts("refill");

        // Local write-through held two cycles, then read back
        wr_req = 1'b1; addr = AW'(16'h0123); wword = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_wr++;
            chk("wt_flush", 32'(flush), 32'd0);
            chk("wt_busy", 32'(busy), 32'd0);
        end
        wr_req = 1'b0;
        model[16'h0123] = 32'hDEADBEEF;
        do_read("wt_read", AW'(16'h0123));
        chk_counts("wt");

        // Write beats a read in the same cycle: read data holds
        held = rword;
        rd_req = 1'b1; wr_req = 1'b1; addr = AW'(16'h4A0); wword = 32'h55AA55AA;
        tick();
        exp_wr++;
        model[16'h4A0] = 32'h55AA55AA;
        rd_req = 1'b0; wr_req = 1'b0;
        chk("prec_hold", rword, held);
        chk_counts("prec");
        do_read("prec_read", AW'(16'h4A0));

        // Remote write at top address: one flush cycle, three busy cycles
        rvalid = 1'b1; raddr = AW'(16'h7FFF); rdata = 32'hA5A5A5A5;
        #1;
        chk("r3_wready", 32'(wready), 32'd1);
        tick();
        rvalid = 1'b0;
        #1;
        chk("r3_wready_drop", 32'(wready), 32'd0);
        model[16'h7FFF] = 32'hA5A5A5A5;
        exp_wr++; exp_fl++;
        busy_cyc = 0; flush_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) busy_cyc++;
            if (flush === 1'b1) flush_cyc++;
            tick();
        end
        chk("r3_busy_cycles", 32'(busy_cyc), 32'd3);
        chk("r3_flush_cycles", 32'(flush_cyc), 32'd1);
        do_read("r3_read", AW'(16'h7FFF));
        chk_counts("r3");

        // Remote write blocked by L1_busy for 5 cycles
        l1_busy = 1'b1; rvalid = 1'b1; raddr = AW'(16'h0200); rdata = 32'h00000777;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("r4_wready_blk", 32'(wready), 32'd0);
            chk("r4_flush_blk", 32'(flush), 32'd0);
            tick();
        end
        l1_busy = 1'b0;
        #1;
        chk("r4_wready", 32'(wready), 32'd1);
        tick();
        rvalid = 1'b0;
        model[16'h0200] = 32'h00000777;
        exp_wr++; exp_fl++;
        chk("r4_flush", 32'(flush), 32'd1);
        wait_idle("r4");
        chk_counts("r4");

        // Reset during HOLD aborts the sequence and clears counters
        remote_write("r5", AW'(16'h0300), 32'hCAFEF00D);
        tick();
        chk("r5_in_hold_busy", 32'(busy), 32'd1);
        chk("r5_in_hold_flush", 32'(flush), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_rd = 0; exp_wr = 0; exp_fl = 0; exp_rd4 = 0;
        chk("r5_busy", 32'(busy), 32'd0);
        chk("r5_flush", 32'(flush), 32'd0);
        chk_counts("r5");
        tick();
        chk("r5_no_flush", 32'(flush), 32'd0);
        do_read("r5_mem_7fff", AW'(16'h7FFF));
        do_read("r5_mem_0123", AW'(16'h0123));
        do_read("r5_mem_0300", AW'(16'h0300));

        // Twenty reads: narrow counters stick at 15
        for (int i = 0; i < 20; i++) do_read("sat_read", AW'(16'h4A0 + (i % 16)));
        chk_counts("sat");
        chk("sat_value", 32'(s_rcnt), 32'd15);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
